// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Host-side command initiator for a registered ALU. Commands {opcode, A, B}
// are buffered in a small FIFO. They are issued to the ALU one at a time, and
// each result/flags pair (or an illegal-opcode error) is returned over a
// valid/ready result port. DONE_CNT counts consumed results and wraps at 8 bits.
module alu_cmd_sequencer #(
   parameter int width = 8,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CMD_VALID,
   output logic             CMD_READY,
   input  logic [3:0]       CMD_OP,
   input  logic [width-1:0] CMD_A,
   input  logic [width-1:0] CMD_B,
   output logic [3:0]       ALU_OPCODE,
   output logic [width-1:0] ALU_A,
   output logic [width-1:0] ALU_B,
   output logic             ALU_EN,
   output logic             ALU_OE,
   input  logic [width-1:0] ALU_RESULT,
   input  logic [3:0]       ALU_FLAGS,
   output logic             RES_VALID,
   input  logic             RES_READY,
   output logic [width-1:0] RES_DATA,
   output logic [3:0]       RES_FLAGS,
   output logic             RES_ERR,
   output logic [7:0]       DONE_CNT
);

   localparam int AW      = $clog2(DEPTH);
   localparam int ENTRY_W = 4 + 2 * width;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   // Opcodes 2..7 (ADD, SUB, AND, OR, XOR, NOT) are the only ones the ALU executes.
   function automatic logic op_legal(input logic [3:0] op);
      return (op >= 4'd2) && (op <= 4'd7);
   endfunction

   // ---------------------------------------------------------------------
   // Command FIFO
   // ---------------------------------------------------------------------
   logic [ENTRY_W-1:0] fifo_mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        count;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic [ENTRY_W-1:0] head;
   logic [3:0]         head_op;
   logic [width-1:0]   head_a;
   logic [width-1:0]   head_b;

   assign full      = (count == (AW+1)'(DEPTH));
   assign empty     = (count == (AW+1)'(0));
   // A full FIFO refuses the push even when a pop happens on the same edge.
   assign push      = CMD_VALID && !full;
   assign CMD_READY = !full;

   assign head    = fifo_mem[rd_ptr];
   assign head_op = head[ENTRY_W-1 -: 4];
   assign head_a  = head[2*width-1 -: width];
   assign head_b  = head[width-1:0];

   // Command storage, written on every accepted push.
   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {CMD_OP, CMD_A, CMD_B};
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Sequencer FSM
   // ---------------------------------------------------------------------
   state_t           state;
   state_t           state_nxt;
   logic [3:0]       alu_opcode_nxt;
   logic [width-1:0] alu_a_nxt;
   logic [width-1:0] alu_b_nxt;
   logic             alu_en_nxt;
   logic             alu_oe_nxt;
   logic             res_valid_nxt;
   logic [width-1:0] res_data_nxt;
   logic [3:0]       res_flags_nxt;
   logic             res_err_nxt;
   logic [7:0]       done_cnt_nxt;

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, FIFO pop and next values of every registered output.
   always_comb begin
      state_nxt      = state;
      pop            = 1'b0;
      alu_opcode_nxt = ALU_OPCODE;
      alu_a_nxt      = ALU_A;
      alu_b_nxt      = ALU_B;
      alu_en_nxt     = 1'b0;
      alu_oe_nxt     = 1'b0;
      res_valid_nxt  = RES_VALID;
      res_data_nxt   = RES_DATA;
      res_flags_nxt  = RES_FLAGS;
      res_err_nxt    = RES_ERR;
      done_cnt_nxt   = DONE_CNT;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop = 1'b1;
               if (op_legal(head_op)) begin
                  alu_opcode_nxt = head_op;
                  alu_a_nxt      = head_a;
                  alu_b_nxt      = head_b;
                  alu_en_nxt     = 1'b1;
                  alu_oe_nxt     = 1'b1;
                  state_nxt      = ISSUE;
               end else begin
                  // Illegal opcode: report an error without touching the ALU.
                  res_data_nxt  = '0;
                  res_flags_nxt = 4'd0;
                  res_err_nxt   = 1'b1;
                  res_valid_nxt = 1'b1;
                  state_nxt     = HOLD;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         ISSUE: begin
            // The ALU samples its inputs at the end of this cycle.
            state_nxt = WAIT;
         end
         WAIT: begin
            res_data_nxt  = ALU_RESULT;
            res_flags_nxt = ALU_FLAGS;
            res_err_nxt   = 1'b0;
            res_valid_nxt = 1'b1;
            state_nxt     = HOLD;
         end
         HOLD: begin
            if (RES_READY) begin
               res_valid_nxt = 1'b0;
               done_cnt_nxt  = DONE_CNT + 8'd1;
               state_nxt     = IDLE;
            end else begin
               state_nxt = HOLD;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Registered ALU drive and result port.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ALU_OPCODE <= 4'd0;
         ALU_A      <= '0;
         ALU_B      <= '0;
         ALU_EN     <= 1'b0;
         ALU_OE     <= 1'b0;
         RES_VALID  <= 1'b0;
         RES_DATA   <= '0;
         RES_FLAGS  <= 4'd0;
         RES_ERR    <= 1'b0;
         DONE_CNT   <= 8'd0;
      end else begin
         ALU_OPCODE <= alu_opcode_nxt;
         ALU_A      <= alu_a_nxt;
         ALU_B      <= alu_b_nxt;
         ALU_EN     <= alu_en_nxt;
         ALU_OE     <= alu_oe_nxt;
         RES_VALID  <= res_valid_nxt;
         RES_DATA   <= res_data_nxt;
         RES_FLAGS  <= res_flags_nxt;
         RES_ERR    <= res_err_nxt;
         DONE_CNT   <= done_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: directed scenarios plus a randomized run
// against a queue-based reference model. A behavioural registered ALU sits
// on the ALU pins and outputs random garbage whenever it is not enabled.
module tb_alu_cmd_sequencer;

   logic       CLK;
   logic       RST;
   logic       CMD_VALID;
   logic       CMD_READY;
   logic [3:0] CMD_OP;
   logic [7:0] CMD_A;
   logic [7:0] CMD_B;
   logic [3:0] ALU_OPCODE;
   logic [7:0] ALU_A;
   logic [7:0] ALU_B;
   logic       ALU_EN;
   logic       ALU_OE;
   logic [7:0] ALU_RESULT;
   logic [3:0] ALU_FLAGS;
   logic       RES_VALID;
   logic       RES_READY;
   logic [7:0] RES_DATA;
   logic [3:0] RES_FLAGS;
   logic       RES_ERR;
   logic [7:0] DONE_CNT;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  done_exp = 8'd0;
   int          en_count = 0;
   int          en_bad   = 0;
   logic        en_prev  = 1'b0;
   logic [12:0] exp_q [$];

   alu_cmd_sequencer #(.width(8), .DEPTH(4)) dut (
      .CLK(CLK), .RST(RST),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .CMD_OP(CMD_OP), .CMD_A(CMD_A), .CMD_B(CMD_B),
      .ALU_OPCODE(ALU_OPCODE), .ALU_A(ALU_A), .ALU_B(ALU_B),
      .ALU_EN(ALU_EN), .ALU_OE(ALU_OE),
      .ALU_RESULT(ALU_RESULT), .ALU_FLAGS(ALU_FLAGS),
      .RES_VALID(RES_VALID), .RES_READY(RES_READY),
      .RES_DATA(RES_DATA), .RES_FLAGS(RES_FLAGS), .RES_ERR(RES_ERR),
      .DONE_CNT(DONE_CNT)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Unsigned ALU arithmetic: returns {OF,SF,ZF,CF, result}.
   function automatic logic [11:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] w;
      case (op)
         4'd2:    w = {1'b0, a} + {1'b0, b};
         4'd3:    w = {1'b0, a} - {1'b0, b};
         4'd4:    w = {1'b0, a & b};
         4'd5:    w = {1'b0, a | b};
         4'd6:    w = {1'b0, a ^ b};
         4'd7:    w = {1'b0, ~a};
         default: w = 9'h000;
      endcase
      return {1'b0, w[7], (w[7:0] == 8'h00), w[8], w[7:0]};
   endfunction

   // Expected result record {err, flags, data} for one command.
   function automatic logic [12:0] expect_res(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      if (op < 4'd2 || op > 4'd7) return {1'b1, 12'h000};
      return {1'b0, alu_ref(op, a, b)};
   endfunction

   // Registered ALU model: computes on EN, otherwise outputs noise.
   always @(posedge CLK) begin
      if (ALU_EN) {ALU_FLAGS, ALU_RESULT} <= alu_ref(ALU_OPCODE, ALU_A, ALU_B);
      else begin
         ALU_RESULT <= 8'($urandom);
         ALU_FLAGS  <= 4'($urandom);
      end
   end

   // EN/OE observer: counts enable cycles and flags OE mismatch or EN longer than a cycle.
   always @(negedge CLK) begin
      if (ALU_EN === 1'b1) en_count++;
      if (ALU_EN !== ALU_OE) en_bad++;
      if (ALU_EN === 1'b1 && en_prev === 1'b1) en_bad++;
      en_prev = ALU_EN;
   end

   task automatic drive_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      CMD_VALID = 1'b1; CMD_OP = op; CMD_A = a; CMD_B = b;
   endtask

   task automatic test_reset();
      RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = 4'd0; CMD_A = 8'd0; CMD_B = 8'd0; RES_READY = 1'b0;
      repeat (3) @(negedge CLK);
      n_checks++;
      if ({ALU_OPCODE, ALU_A, ALU_B, ALU_EN, ALU_OE} !== 22'h0) begin
         n_fail++; $display("FAIL reset_alu: got %h required 0", {ALU_OPCODE, ALU_A, ALU_B, ALU_EN, ALU_OE});
      end
      n_checks++;
      if ({RES_VALID, RES_DATA, RES_FLAGS, RES_ERR} !== 14'h0) begin
         n_fail++; $display("FAIL reset_res: got %h required 0", {RES_VALID, RES_DATA, RES_FLAGS, RES_ERR});
      end
      n_checks++;
      if (DONE_CNT !== 8'd0) begin
         n_fail++; $display("FAIL reset_done: got %0d required 0", DONE_CNT);
      end
      RST = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (CMD_READY !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b required 1", CMD_READY);
      end
      done_exp = 8'd0;
   endtask

   task automatic test_add_latency();
      int en0;
      en0 = en_count;
      RES_READY = 1'b0;
      drive_cmd(4'd2, 8'hF0, 8'h20);
      @(negedge CLK);                 // accepted at T0
      CMD_VALID = 1'b0;
      n_checks++;
      if (ALU_EN !== 1'b0 || RES_VALID !== 1'b0) begin
         n_fail++; $display("FAIL add_t0: got en=%b valid=%b required 0 0", ALU_EN, RES_VALID);
      end
      @(negedge CLK);                 // after T1
      n_checks++;
      if ({ALU_EN, ALU_OE, ALU_OPCODE, ALU_A, ALU_B} !== {1'b1, 1'b1, 4'd2, 8'hF0, 8'h20}) begin
         n_fail++; $display("FAIL add_issue: got en=%b oe=%b op=%h a=%h b=%h required 1 1 2 f0 20",
                            ALU_EN, ALU_OE, ALU_OPCODE, ALU_A, ALU_B);
      end
      @(negedge CLK);                 // after T2
      n_checks++;
      if ({ALU_EN, ALU_OE, RES_VALID, ALU_OPCODE, ALU_A, ALU_B} !== {3'b000, 4'd2, 8'hF0, 8'h20}) begin
         n_fail++; $display("FAIL add_wait: got en=%b oe=%b valid=%b op=%h a=%h b=%h required 0 0 0 2 f0 20",
                            ALU_EN, ALU_OE, RES_VALID, ALU_OPCODE, ALU_A, ALU_B);
      end
      @(negedge CLK);                 // after T3
      n_checks++;
      if ({RES_VALID, RES_ERR, RES_FLAGS, RES_DATA} !== {1'b1, 1'b0, 4'b0001, 8'h10}) begin
         n_fail++; $display("FAIL add_result: got valid=%b err=%b flags=%b data=%h required 1 0 0001 10",
                            RES_VALID, RES_ERR, RES_FLAGS, RES_DATA);
      end
      RES_READY = 1'b1;
      @(negedge CLK);
      RES_READY = 1'b0;
      done_exp = done_exp + 8'd1;
      n_checks++;
      if (RES_VALID !== 1'b0 || DONE_CNT !== done_exp) begin
         n_fail++; $display("FAIL add_done: got valid=%b cnt=%0d required 0 %0d", RES_VALID, DONE_CNT, done_exp);
      end
      #1;
      n_checks++;
      if (en_count - en0 !== 1 || en_bad !== 0) begin
         n_fail++; $display("FAIL add_en_pulse: got pulses=%0d bad=%0d required 1 0", en_count - en0, en_bad);
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] got [2];
      int          t [2];
      int          n;
      RES_READY = 1'b1;
      drive_cmd(4'd3, 8'h05, 8'h03);
      @(negedge CLK);
      drive_cmd(4'd4, 8'hCC, 8'h0F);
      @(negedge CLK);
      CMD_VALID = 1'b0;
      n = 0;
      for (int c = 0; c < 30 && n < 2; c++) begin
         if (RES_VALID === 1'b1) begin
            got[n] = {RES_FLAGS, RES_DATA};
            t[n]   = c;
            n++;
         end
         @(negedge CLK);
      end
      RES_READY = 1'b0;
      n_checks++;
      if (n !== 2) begin
         n_fail++; $display("FAIL b2b_count: got %0d results required 2", n);
      end else begin
         n_checks++;
         if (got[0] !== 12'h002 || got[1] !== 12'h00C) begin
            n_fail++; $display("FAIL b2b_data: got %h %h required 002 00c", got[0], got[1]);
         end
         n_checks++;
         if (t[1] - t[0] !== 4) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d cycles required 4", t[1] - t[0]);
         end
      end
      done_exp = done_exp + 8'd2;
      n_checks++;
      if (DONE_CNT !== done_exp) begin
         n_fail++; $display("FAIL b2b_done: got %0d required %0d", DONE_CNT, done_exp);
      end
   endtask

   task automatic test_illegal();
      int en0;
      en0 = en_count;
      RES_READY = 1'b0;
      drive_cmd(4'hA, 8'h11, 8'h22);
      @(negedge CLK);                 // T0
      CMD_VALID = 1'b0;
      n_checks++;
      if (RES_VALID !== 1'b0) begin
         n_fail++; $display("FAIL ill_t0: got valid=%b required 0", RES_VALID);
      end
      @(negedge CLK);                 // after T1
      n_checks++;
      if ({RES_VALID, RES_ERR, RES_FLAGS, RES_DATA, ALU_EN} !== {1'b1, 1'b1, 4'd0, 8'h00, 1'b0}) begin
         n_fail++; $display("FAIL ill_result: got valid=%b err=%b flags=%b data=%h en=%b required 1 1 0000 00 0",
                            RES_VALID, RES_ERR, RES_FLAGS, RES_DATA, ALU_EN);
      end
      RES_READY = 1'b1;
      @(negedge CLK);
      RES_READY = 1'b0;
      done_exp = done_exp + 8'd1;
      #1;
      n_checks++;
      if (DONE_CNT !== done_exp || en_count !== en0) begin
         n_fail++; $display("FAIL ill_done: got cnt=%0d pulses=%0d required %0d 0", DONE_CNT, en_count - en0, done_exp);
      end
   endtask

   task automatic test_fifo_full();
      int          accepted;
      int          got;
      logic [12:0] e;
      logic [3:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      RES_READY = 1'b0;
      accepted = 0;
      for (int i = 0; i < 6; i++) begin
         op = 4'($urandom_range(2, 7)); a = 8'($urandom); b = 8'($urandom);
         drive_cmd(op, a, b);
         if (CMD_READY === 1'b1) begin
            accepted++;
            exp_q.push_back(expect_res(op, a, b));
         end
         @(negedge CLK);
      end
      CMD_VALID = 1'b0;
      n_checks++;
      if (accepted !== 5 || CMD_READY !== 1'b0) begin
         n_fail++; $display("FAIL full_accept: got accepted=%0d ready=%b required 5 0", accepted, CMD_READY);
      end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (RES_VALID !== 1'b1 || exp_q.size() == 0 || {RES_ERR, RES_FLAGS, RES_DATA} !== exp_q[0]) begin
            n_fail++; $display("FAIL full_hold: got valid=%b res=%h required 1 %h", RES_VALID,
                               {RES_ERR, RES_FLAGS, RES_DATA}, (exp_q.size() != 0) ? exp_q[0] : 13'h0);
         end
         @(negedge CLK);
      end
      RES_READY = 1'b1;
      got = 0;
      for (int c = 0; c < 60 && got < 5; c++) begin
         if (RES_VALID === 1'b1) begin
            e = exp_q.pop_front();
            got++;
            n_checks++;
            if ({RES_ERR, RES_FLAGS, RES_DATA} !== e) begin
               n_fail++; $display("FAIL full_drain: got %h required %h", {RES_ERR, RES_FLAGS, RES_DATA}, e);
            end
         end
         @(negedge CLK);
      end
      RES_READY = 1'b0;
      done_exp = done_exp + 8'(got);
      n_checks++;
      if (got !== 5 || CMD_READY !== 1'b1 || DONE_CNT !== done_exp) begin
         n_fail++; $display("FAIL full_end: got results=%0d ready=%b cnt=%0d required 5 1 %0d",
                            got, CMD_READY, DONE_CNT, done_exp);
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      int          en0;
      int          stray;
      int          w;
      logic [12:0] e;
      RES_READY = 1'b0;
      drive_cmd(4'd2, 8'h33, 8'h44);
      @(negedge CLK);                 // T0
      drive_cmd(4'd6, 8'h0F, 8'hF0);
      @(negedge CLK);                 // T1: ADD in ISSUE, XOR buffered
      CMD_VALID = 1'b0;
      @(negedge CLK);                 // T2: ADD in WAIT
      RST = 1'b1;
      #1;
      n_checks++;
      if ({ALU_OPCODE, ALU_A, ALU_B, ALU_EN, ALU_OE, RES_VALID, RES_DATA, RES_FLAGS, RES_ERR, DONE_CNT} !== 44'h0
          || CMD_READY !== 1'b1) begin
         n_fail++; $display("FAIL mid_reset_outs: got %h ready=%b required 0 1",
            {ALU_OPCODE, ALU_A, ALU_B, ALU_EN, ALU_OE, RES_VALID, RES_DATA, RES_FLAGS, RES_ERR, DONE_CNT}, CMD_READY);
      end
      @(negedge CLK);
      RST = 1'b0;
      done_exp = 8'd0;
      en0 = en_count;
      stray = 0;
      repeat (6) begin
         @(negedge CLK);
         if (RES_VALID !== 1'b0) stray++;
      end
      #1;
      n_checks++;
      if (stray !== 0 || en_count !== en0 || DONE_CNT !== 8'd0) begin
         n_fail++; $display("FAIL mid_flush: got stray=%0d pulses=%0d cnt=%0d required 0 0 0",
                            stray, en_count - en0, DONE_CNT);
      end
      drive_cmd(4'd3, 8'h03, 8'h05);
      e = expect_res(4'd3, 8'h03, 8'h05);
      @(negedge CLK);
      CMD_VALID = 1'b0;
      w = 0;
      while (RES_VALID !== 1'b1 && w < 20) begin @(negedge CLK); w++; end
      n_checks++;
      if (RES_VALID !== 1'b1 || {RES_ERR, RES_FLAGS, RES_DATA} !== e) begin
         n_fail++; $display("FAIL mid_after: got valid=%b res=%h required 1 %h", RES_VALID, {RES_ERR, RES_FLAGS, RES_DATA}, e);
      end
      RES_READY = 1'b1;
      @(negedge CLK);
      RES_READY = 1'b0;
      done_exp = 8'd1;
      n_checks++;
      if (DONE_CNT !== done_exp) begin
         n_fail++; $display("FAIL mid_done: got %0d required %0d", DONE_CNT, done_exp);
      end
   endtask

   task automatic test_random_wrap();
      int          got;
      logic [12:0] e;
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      done_exp = 8'd0;
      exp_q.delete();
      got = 0;
      fork
         begin : producer
            int w;
            for (int i = 0; i < 256; i++) begin
               if ($urandom_range(0, 3) != 0) CMD_OP = 4'($urandom_range(2, 7));
               else                           CMD_OP = 4'($urandom_range(0, 15));
               CMD_A = 8'($urandom); CMD_B = 8'($urandom); CMD_VALID = 1'b1;
               w = 0;
               while (CMD_READY !== 1'b1 && w < 200) begin @(negedge CLK); w++; end
               if (CMD_READY !== 1'b1) begin
                  n_checks++; n_fail++;
                  $display("FAIL rand_push_timeout: got ready=%b required 1", CMD_READY);
                  break;
               end
               exp_q.push_back(expect_res(CMD_OP, CMD_A, CMD_B));
               @(negedge CLK);
               CMD_VALID = 1'b0;
               repeat ($urandom_range(0, 2)) @(negedge CLK);
            end
            CMD_VALID = 1'b0;
         end
         begin : consumer
            int c;
            c = 0;
            while (got < 256 && c < 20000) begin
               RES_READY = ($urandom_range(0, 3) != 0);
               if (RES_VALID === 1'b1 && RES_READY) begin
                  n_checks++;
                  if (exp_q.size() == 0) begin
                     n_fail++; $display("FAIL rand_extra: got res=%h required none", {RES_ERR, RES_FLAGS, RES_DATA});
                  end else begin
                     e = exp_q.pop_front();
                     if ({RES_ERR, RES_FLAGS, RES_DATA} !== e) begin
                        n_fail++; $display("FAIL rand_result %0d: got %h required %h", got, {RES_ERR, RES_FLAGS, RES_DATA}, e);
                     end
                  end
                  n_checks++;
                  if (DONE_CNT !== done_exp) begin
                     n_fail++; $display("FAIL rand_count %0d: got %0d required %0d", got, DONE_CNT, done_exp);
                  end
                  done_exp = done_exp + 8'd1;
                  got++;
               end
               @(negedge CLK);
               c++;
            end
            RES_READY = 1'b0;
         end
      join
      #1;
      n_checks++;
      if (got !== 256 || exp_q.size() != 0 || DONE_CNT !== 8'd0 || en_bad !== 0) begin
         n_fail++; $display("FAIL rand_wrap: got results=%0d left=%0d cnt=%0d en_bad=%0d required 256 0 0 0",
                            got, exp_q.size(), DONE_CNT, en_bad);
      end
   endtask

   initial begin
      test_reset();
      test_add_latency();
      test_back_to_back();
      test_illegal();
      test_fifo_full();
      test_reset_mid();
      test_random_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command-side initiator for the registered ALU: accepts {opcode, A, B} commands from a host over a valid/ready port and buffers them in a small FIFO.
- Drives the ALU's OPCODE/A/B/EN/OE pins one command at a time, captures the ALU result and the OF/SF/ZF/CF flags, and returns them over a valid/ready result port.
- Sits between the host/testbench stimulus layer and the alu instance.

Parameters:
- width, 8, data width of A, B and result; must match the ALU width.
- DEPTH, 4, command FIFO depth in entries; a power of two, at least 2.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  asynchronous, active-high reset.
- CMD_VALID  input  1  host command valid.
- CMD_READY  output  1  FIFO not full; a command is accepted on a posedge where CMD_VALID and CMD_READY are both 1.
- CMD_OP  input  4  opcode.
- CMD_A  input  width  operand A.
- CMD_B  input  width  operand B.
- ALU_OPCODE  output  4  to ALU OPCODE.
- ALU_A  output  width  to ALU A.
- ALU_B  output  width  to ALU B.
- ALU_EN  output  1  to ALU EN.
- ALU_OE  output  1  to ALU OE.
- ALU_RESULT  input  width  from ALU_OUT.
- ALU_FLAGS  input  4  from ALU {OF,SF,ZF,CF}.
- RES_VALID  output  1  result available.
- RES_READY  input  1  host consumes the result.
- RES_DATA  output  width  captured result.
- RES_FLAGS  output  4  captured {OF,SF,ZF,CF}.
- RES_ERR  output  1  set when the command carried an illegal opcode.
- DONE_CNT  output  8  count of completed results; wraps 255 to 0.

Behaviour:
- Reset (async, RST=1): FIFO flushed (empty, pointers 0); state IDLE.
- Every registered output resets to 0: ALU_*, RES_*, DONE_CNT. CMD_READY is 1 as soon as RST deasserts.
- Legal opcodes are 2 through 7 (ADD, SUB, AND, OR, XOR, NOT). All other values are illegal.
- All ALU_* outputs are registered. ALU_EN is 1 for exactly one cycle per legal command; ALU_OE is 1 in that same cycle only. Both are 0 at all other times.
- FSM states and transitions:
  - IDLE: if the FIFO is not empty and the head opcode is legal, load ALU_OPCODE/A/B from the head, set ALU_EN=ALU_OE=1, pop the head, go to ISSUE.
  - IDLE: if the head opcode is illegal, pop it, set RES_DATA=0, RES_FLAGS=0, RES_ERR=1, RES_VALID=1, go to HOLD. The ALU is never enabled for an illegal command.
  - ISSUE (the ALU samples at the end of this cycle): clear ALU_EN and ALU_OE, go to WAIT. ALU_OPCODE/A/B hold their values.
  - WAIT: capture ALU_RESULT into RES_DATA and ALU_FLAGS into RES_FLAGS, set RES_ERR=0 and RES_VALID=1, go to HOLD.
  - HOLD: RES_* are stable while RES_VALID=1. On RES_READY=1: RES_VALID goes to 0, DONE_CNT increments, go to IDLE.
- Latency: a command accepted at edge T0 into an empty FIFO with the FSM in IDLE gives ALU_EN=1 during cycle T1–T2 and RES_VALID=1 after T3. Illegal commands give RES_VALID=1 after T1.
- Throughput: at most one result per 4 cycles, with RES_READY held high.
- FIFO full: CMD_READY=0. A push is refused when full even if a pop occurs on the same edge.
- Pushes are accepted in every FSM state.
- Push and pop on the same edge with the FIFO neither empty nor full: both take effect and the occupancy is unchanged.
- Empty FIFO with CMD_VALID=1: the command is written at edge T0 and is not bypassed. It is issued from IDLE on the following cycle.
- Commands complete strictly in FIFO order. In HOLD, no new command is issued until the result is consumed.
- FIFO pointers wrap modulo DEPTH.
- Reset mid-operation (any state): immediate return to the reset values. Any in-flight result is discarded and DONE_CNT is not incremented.

Test Plan:
- ALU built unsigned: push ADD, A=8'hF0, B=8'h20 -> ALU_EN pulses for one cycle; RES_VALID rises 3 cycles after accept; RES_DATA=8'h10, RES_FLAGS=4'b0001 (CF), RES_ERR=0, DONE_CNT=1.
- Push SUB 8'h05 - 8'h03 then AND 8'hCC & 8'h0F back-to-back, RES_READY=1 -> results arrive in order: 8'h02 with flags 0, then 8'h0C with flags 0; results spaced 4 cycles apart.
- Push opcode 4'hA, A=8'h11, B=8'h22 -> ALU_EN stays 0; RES_ERR=1, RES_DATA=0, RES_FLAGS=0; DONE_CNT increments after RES_READY.
- Hold RES_READY=0 and offer 6 commands -> 5 accepted (1 in HOLD, 4 in FIFO); CMD_READY=0 afterwards; RES_DATA stays stable. Release RES_READY -> all 5 results drain in order and CMD_READY returns to 1.
- Assert RST during WAIT -> all outputs 0 within the same cycle; FIFO empty; no result is produced; a new command afterwards completes normally.
- Issue 256 commands -> DONE_CNT wraps to 0.
